// File: rtl/obstacle_pkg.sv
// obstacle_pkg
// Shared definitions for the obstacle generation path:
//   - default board geometry (width/height in cells)
//   - 16-bit LFSR seed and feedback tap mask
//   - spawner FSM state encoding (RUN / HALT)
package obstacle_pkg;

  // Default playfield geometry in cells.
  localparam int BOARD_WIDTH_DEF  = 9;
  localparam int BOARD_HEIGHT_DEF = 16;

  // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1.
  // Tap mask selects register bits 15, 13, 12 and 10 (taps 16, 14, 13, 11).
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

endpackage : obstacle_pkg

// File: rtl/lfsr16.sv
// lfsr16
// Free-running 16-bit Fibonacci LFSR used as the obstacle pattern source.
// It advances on every cycle that is not a reset cycle, independent of the
// game state, so the pattern keeps evolving while the game is halted.
//
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous, active-high; reloads the seed
//   q     - current LFSR state (never zero)
module lfsr16
  import obstacle_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  logic fb;

  assign fb = ^(q & LFSR_TAPS);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= LFSR_SEED;
    end else if (q == 16'h0000) begin
      // Unreachable for a maximal-length polynomial started from a non-zero
      // seed; recovers from lock-up should the state ever be corrupted.
      q <= LFSR_SEED;
    end else begin
      q <= {q[14:0], fb};
    end
  end

endmodule : lfsr16

// File: rtl/obstacle_spawner.sv
// obstacle_spawner
// Generates the stream of new top rows for the obstacle board. A period
// counter issues a one-cycle update_obstacle strobe every `period` cycles;
// the row that the board will consume on the next strobe is held in
// row_data. Rows follow the pattern: GAP_ROWS empty rows, one obstacle row,
// repeating (the reset value of row_data counts as the first empty row).
// Every SPEEDUP_ROWS obstacle rows the period shrinks by PERIOD_STEP,
// saturating at MIN_PERIOD. game_Over freezes everything except the LFSR.
//
// Ports:
//   clk             - clock, rising edge
//   reset           - synchronous, active-high
//   game_Over       - 1 freezes spawning
//   update_obstacle - registered one-cycle shift strobe to the board
//   row_data        - registered next top row, stable during the strobe
module obstacle_spawner
  import obstacle_pkg::*;
#(
  parameter int board_width  = BOARD_WIDTH_DEF,
  parameter int START_PERIOD = 50000000,
  parameter int MIN_PERIOD   = 12500000,
  parameter int PERIOD_STEP  = 2500000,
  parameter int SPEEDUP_ROWS = 8,
  parameter int GAP_ROWS     = 2
)
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   game_Over,
  output logic                   update_obstacle,
  output logic [board_width-1:0] row_data
);

  // Counter widths.
  localparam int PW = $clog2(START_PERIOD + 1);
  localparam int GW = (GAP_ROWS > 0) ? $clog2(GAP_ROWS + 1) : 1;
  localparam int RW = (SPEEDUP_ROWS > 1) ? $clog2(SPEEDUP_ROWS + 1) : 1;
  localparam int IW = $clog2(board_width);

  localparam logic [PW-1:0] START_P   = PW'(START_PERIOD);
  localparam logic [PW-1:0] MIN_P     = PW'(MIN_PERIOD);
  localparam logic [PW-1:0] STEP_P    = PW'(PERIOD_STEP);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_ROWS);
  localparam logic [RW-1:0] ROWS_LAST = RW'(SPEEDUP_ROWS - 1);

  state_t          state;
  state_t          state_nxt;
  logic            count_en;
  logic            count_restart;
  logic            terminal;
  logic            load_row;
  logic [PW-1:0]   tick_cnt;
  logic [PW-1:0]   period;
  logic [PW-1:0]   period_last;
  logic [GW-1:0]   gap_cnt;
  logic [RW-1:0]   row_cnt;
  logic [15:0]     lfsr_q;

  // Obstacle row from the LFSR state. The low board_width bits give the
  // raw pattern (board_width must lie in 8..16); the top nibble, folded
  // into range, picks one cell that is always left open. A row that ends
  // up empty gets one blocked cell away from the opening.
  function automatic logic [board_width-1:0] make_row(input logic [15:0] s);
    logic [board_width-1:0] r;
    logic [4:0]             g5;
    logic [IW-1:0]          g;
    r  = s[board_width-1:0];
    g5 = {1'b0, s[15:12]};
    if (g5 >= 5'(board_width)) begin
      g5 = g5 - 5'(board_width);
    end
    g    = g5[IW-1:0];
    r[g] = 1'b0;
    if (r == '0) begin
      if (g == '0) begin
        r[board_width-1] = 1'b1;
      end else begin
        r[0] = 1'b1;
      end
    end
    return r;
  endfunction

  // Period after one speed-up: subtract PERIOD_STEP but never go below
  // MIN_PERIOD; compared as a difference so the subtraction cannot wrap.
  function automatic logic [PW-1:0] next_period(input logic [PW-1:0] p);
    if (p <= MIN_P) begin
      return MIN_P;
    end
    if ((p - MIN_P) >= STEP_P) begin
      return p - STEP_P;
    end
    return MIN_P;
  endfunction

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  // FSM: state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (game_Over)  state_nxt = HALT;
      HALT:    if (!game_Over) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // FSM: control decode. Counting only happens in RUN with game_Over low,
  // so a game_Over that rises on the terminal count suppresses the strobe
  // and leaves tick_cnt holding. Leaving HALT restarts the count.
  always_comb begin
    count_en      = 1'b0;
    count_restart = 1'b0;
    case (state)
      RUN:     count_en      = !game_Over;
      HALT:    count_restart = !game_Over;
      default: count_en      = 1'b0;
    endcase
  end

  assign period_last = period - PW'(1);
  assign terminal    = (tick_cnt == period_last);
  // The board shifts on the strobe; the next row is prepared on the edge
  // that ends it, so row_data never moves while update_obstacle is high.
  assign load_row    = update_obstacle && count_en;

  // Period counter and strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt        <= '0;
      update_obstacle <= 1'b0;
    end else begin
      update_obstacle <= count_en && terminal;
      if (count_restart) begin
        tick_cnt <= '0;
      end else if (count_en) begin
        tick_cnt <= terminal ? '0 : tick_cnt + PW'(1);
      end
    end
  end

  // Row sequencing, obstacle counting and speed-up. A new period is picked
  // up by the terminal compare on the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_data <= '0;
      gap_cnt  <= '0;
      row_cnt  <= '0;
      period   <= START_P;
    end else if (load_row) begin
      if (gap_cnt == GAP_LAST) begin
        row_data <= make_row(lfsr_q);
        gap_cnt  <= '0;
        if (row_cnt == ROWS_LAST) begin
          row_cnt <= '0;
          period  <= next_period(period);
        end else begin
          row_cnt <= row_cnt + RW'(1);
        end
      end else begin
        row_data <= '0;
        gap_cnt  <= gap_cnt + GW'(1);
      end
    end
  end

endmodule : obstacle_spawner

// File: tb/tb_obstacle_spawner.sv
// tb_obstacle_spawner
// Directed bench for obstacle_spawner with START_PERIOD=4, MIN_PERIOD=2,
// PERIOD_STEP=1, SPEEDUP_ROWS=2, GAP_ROWS=1, board_width=9.
// Pulse times are hand-computed; obstacle row contents come from a small
// reference LFSR that follows the same reset/advance rules as the design.
module tb_obstacle_spawner;

  logic       clk;
  logic       reset;
  logic       game_Over;
  logic       update_obstacle;
  logic [8:0] row_data;

  int n_assert = 0;
  int n_fail   = 0;

  // Pulse cycles after reset release: period 4 until the 2nd obstacle row
  // (loaded after pulse 4), 3 until the 4th (after pulse 8), then 2.
  int ptab [20] = '{4, 8, 12, 16, 19, 22, 25, 28, 30, 32,
                    34, 36, 38, 40, 42, 44, 46, 48, 50, 52};

  logic [15:0] m;
  logic [15:0] prev_m;

  obstacle_spawner #(
    .board_width  (9),
    .START_PERIOD (4),
    .MIN_PERIOD   (2),
    .PERIOD_STEP  (1),
    .SPEEDUP_ROWS (2),
    .GAP_ROWS     (1)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .game_Over       (game_Over),
    .update_obstacle (update_obstacle),
    .row_data        (row_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: x^16+x^14+x^13+x^11+1, shifting left, seed ACE1.
  // prev_m is the state that was current just before the latest edge.
  always @(posedge clk) begin
    prev_m <= m;
    if (reset) m <= 16'hACE1;
    else       m <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
  end

  function automatic logic [8:0] exp_row(input logic [15:0] s);
    logic [8:0] r;
    logic [4:0] g5;
    logic [3:0] g;
    r  = s[8:0];
    g5 = {1'b0, s[15:12]};
    if (g5 >= 5'd9) g5 = g5 - 5'd9;
    g    = g5[3:0];
    r[g] = 1'b0;
    if (r == 9'h000) r = (g == 4'd0) ? 9'h100 : 9'h001;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int         k;
    logic       last_p;
    logic       ep;
    logic [8:0] er;
    logic [8:0] held;

    reset     = 1'b1;
    game_Over = 1'b0;
    step();
    step();
    check("rst_pulse", 32'(update_obstacle), 32'(0));
    check("rst_row",   32'(row_data),        32'(0));
    reset = 1'b0;

    // Free run: pulse timing through two speed-ups, row contents each cycle.
    k      = 0;
    last_p = 1'b0;
    er     = 9'h000;
    for (int c = 1; c <= 52; c++) begin
      step();
      if (last_p) er = (k % 2 == 0) ? exp_row(prev_m) : 9'h000;
      ep = (k < 20) && (c == ptab[k]);
      if (ep) k++;
      check($sformatf("run_pulse_c%0d", c), 32'(update_obstacle), 32'(ep));
      check($sformatf("run_row_c%0d", c),   32'(row_data),        32'(er));
      if (last_p && (k % 2 == 0)) begin
        check($sformatf("run_open_c%0d", c),    32'(row_data != 9'h1FF), 32'(1));
        check($sformatf("run_nonzero_c%0d", c), 32'(row_data != 9'h000), 32'(1));
      end
      last_p = ep;
    end

    // Fresh reset, then halt at tick_cnt==2 with an obstacle row on show.
    reset = 1'b1;
    step();
    check("rst2_pulse", 32'(update_obstacle), 32'(0));
    check("rst2_row",   32'(row_data),        32'(0));
    reset = 1'b0;
    held  = 9'h000;
    for (int c = 1; c <= 10; c++) begin
      step();
      check($sformatf("pre_pulse_c%0d", c), 32'(update_obstacle), 32'((c == 4) || (c == 8)));
      if (c == 9) begin
        held = exp_row(prev_m);
        check("pre_obstacle_row", 32'(row_data), 32'(held));
      end
    end
    game_Over = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      check($sformatf("halt_pulse_%0d", i), 32'(update_obstacle), 32'(0));
      check($sformatf("halt_row_%0d", i),   32'(row_data),        32'(held));
    end
    // First edge after release returns to RUN with the count at 0; the
    // pulse then follows a full period of 4 counting cycles.
    game_Over = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      step();
      check($sformatf("resume_pulse_%0d", n), 32'(update_obstacle), 32'(n == 5));
      check($sformatf("resume_row_%0d", n),   32'(row_data),        32'(held));
    end
    step();
    check("gap_row_after_resume", 32'(row_data), 32'(0));
    step();
    step();
    // tick_cnt is now 3: game_Over lands on the terminal count.
    game_Over = 1'b1;
    step();
    check("go_term_pulse_0", 32'(update_obstacle), 32'(0));
    step();
    check("go_term_pulse_1", 32'(update_obstacle), 32'(0));
    game_Over = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      step();
      check($sformatf("resume2_pulse_%0d", n), 32'(update_obstacle), 32'(n == 5));
      check($sformatf("resume2_row_%0d", n),   32'(row_data),        32'(0));
    end
    step();
    er = exp_row(prev_m);
    check("obstacle_after_resume2", 32'(row_data), 32'(er));
    step();
    // Period is 3 now and tick_cnt is 2: a pulse is due on the next edge.
    reset = 1'b1;
    step();
    check("rst_due_pulse", 32'(update_obstacle), 32'(0));
    check("rst_due_row",   32'(row_data),        32'(0));
    reset = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      step();
      check($sformatf("post_rst_pulse_%0d", n), 32'(update_obstacle), 32'(n == 4));
      check($sformatf("post_rst_row_%0d", n),   32'(row_data),        32'(0));
    end
    for (int n = 1; n <= 4; n++) begin
      step();
      check($sformatf("pre_force_pulse_%0d", n), 32'(update_obstacle), 32'(n == 4));
    end
    // Obstacle row is loaded on the next edge; present an all-ones LFSR
    // state (g = 15 folds to 6).
    force dut.lfsr_q = 16'hFFFF;
    step();
    release dut.lfsr_q;
    check("forced_row",      32'(row_data),    32'(9'h1BF));
    check("forced_row_bit6", 32'(row_data[6]), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_obstacle_spawner
